mac_dot_scheduler: RTL and testbench
====================================

MAC_DOT_SCHEDULER -- requirements
Module: mac_dot_scheduler

Interface
REQ-001 Parameter LEN_W, default 8, width of the dot-product length field.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 cmd0_valid/cmd1_valid  in  1 each  requester N offers a job.
REQ-005 cmd0_ready/cmd1_ready  out  1 each  job accepted when valid&ready.
REQ-006 cmd0_len/cmd1_len  in  LEN_W each  number of A/B pairs in the job.
REQ-007 d0_valid/d1_valid  in  1 each  operand pair valid.
REQ-008 d0_ready/d1_ready  out  1 each  operand pair consumed when valid&ready.
REQ-009 d0_a, d0_b, d1_a, d1_b  in  32 each  IEEE-754 single operands.
REQ-010 mac_ivalid  out  1  pair valid to the MAC datapath.
REQ-011 mac_control  out  1  restart accumulation; high with the first pair of a job only.
REQ-012 mac_a/mac_b  out  32 each  operands to the MAC.
REQ-013 mac_ovalid  in  1  MAC result-valid strobe, one per issued pair, in order.
REQ-014 mac_result  in  32  MAC running accumulator.
REQ-015 res_valid  out  1  job result available.
REQ-016 res_ready  in  1  result consumed when res_valid&res_ready.
REQ-017 res_data  out  32  final dot product; res_id  out  1  owning requester.

Function
REQ-018 FSM states: IDLE, STREAM, DRAIN, HOLD.
REQ-019 IDLE: cmdN_ready is high only for the winner of arbitration and only in IDLE; acceptance latches len and owner id, clears issue and return counters, and moves to STREAM (len>0) or HOLD (len=0).
REQ-020 Arbitration is round-robin: with both cmd_valid high, grant the requester not granted last; after reset, requester 0 has priority.
REQ-021 len=0: res_data is 32'h00000000, res_valid asserts the cycle after acceptance, and the MAC is not driven.
REQ-022 STREAM: dN_ready = (owner==N) & (issued<len); the other requester's d_ready is 0.
REQ-023 mac_ivalid equals the owner's d_valid&d_ready in the same cycle (combinational pass-through); mac_a/mac_b mux the owner's operands.
REQ-024 mac_control is high exactly when mac_ivalid is high and issued==0.
REQ-025 Bubbles (d_valid low) are allowed; mac_ivalid is 0 in bubble cycles and counters hold.
REQ-026 When issued reaches len, STREAM moves to DRAIN.
REQ-027 The returned counter increments on every mac_ovalid in STREAM or DRAIN; mac_ovalid in IDLE or HOLD is ignored.
REQ-028 On the mac_ovalid that makes returned==len, mac_result is captured into res_data, res_id is set to the owner, and the FSM moves to HOLD with res_valid high the next cycle.
REQ-029 HOLD: res_valid stays high and res_data/res_id are stable until res_ready; on handshake the FSM returns to IDLE and a new command may be accepted the following cycle.
REQ-030 Counters are LEN_W+1 bits wide; len = 2^LEN_W-1 does not wrap.
REQ-031 Commands held pending during a job stay un-acknowledged; cmd_ready is 0 outside IDLE.

Reset
REQ-032 resetn low, at any time including mid-job, forces IDLE, clears counters, sets last-grant to 1 (so requester 0 wins next), and drives cmd*_ready=0, d*_ready=0, mac_ivalid=0, mac_control=0, res_valid=0, res_data=0, res_id=0.
REQ-033 After reset release, in-flight MAC returns from the aborted job are ignored per REQ-027.

Verification
REQ-034 Req0 len=3, pairs (1.0,2.0),(3.0,4.0),(5.0,6.0), MAC model latency 7 -> mac_control high on first pair only; res_data=0x42300000 (44.0), res_id=0.
REQ-035 Both cmd_valid high at once, two len=1 jobs each -> grant order 0,1,0,1; res_id alternates accordingly.
REQ-036 Req1 len=0 -> res_valid the cycle after acceptance, res_data=0, mac_ivalid never asserted.
REQ-037 len=4 with d_valid toggling every other cycle, and res_ready held low 5 cycles -> exactly 4 mac_ivalid pulses; res_data stable while res_valid&!res_ready.
REQ-038 resetn asserted after 2 of 5 pairs issued -> all outputs 0 immediately; stale mac_ovalid ignored; next len=1 job from req0 returns the correct single product.

Source files
------------

// File: rtl/mac_dot_scheduler.sv
// Dot-product job scheduler: arbitrates two requesters, streams their operand pairs
// into an external MAC and returns the final accumulator value to the job owner.
module mac_dot_scheduler #(
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd0_valid,
  output logic             cmd0_ready,
  input  logic [LEN_W-1:0] cmd0_len,
  input  logic             cmd1_valid,
  output logic             cmd1_ready,
  input  logic [LEN_W-1:0] cmd1_len,
  input  logic             d0_valid,
  output logic             d0_ready,
  input  logic [31:0]      d0_a,
  input  logic [31:0]      d0_b,
  input  logic             d1_valid,
  output logic             d1_ready,
  input  logic [31:0]      d1_a,
  input  logic [31:0]      d1_b,
  output logic             mac_ivalid,
  output logic             mac_control,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  input  logic             mac_ovalid,
  input  logic [31:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_id
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]     state;
  logic [LEN_W:0] len_q;
  logic [LEN_W:0] issued;
  logic [LEN_W:0] returned;
  logic           owner;
  logic           last_grant;

  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           accept_id;
  logic [LEN_W:0] accept_len;
  logic           can_issue;
  logic [LEN_W:0] issued_nxt;
  logic [LEN_W:0] returned_nxt;
  logic           ret_fire;
  logic           last_ret;

  // Round-robin: on contention the requester not granted last wins.
  assign grant0 = cmd0_valid & (~cmd1_valid | last_grant);
  assign grant1 = cmd1_valid & (~cmd0_valid | ~last_grant);

  // Ready is masked by resetn so a valid held during reset is never acknowledged.
  assign cmd0_ready = resetn & (state == IDLE) & grant0;
  assign cmd1_ready = resetn & (state == IDLE) & grant1;

  assign accept     = cmd0_ready | cmd1_ready;
  assign accept_id  = cmd1_ready;
  assign accept_len = cmd1_ready ? {1'b0, cmd1_len} : {1'b0, cmd0_len};

  assign can_issue = (state == STREAM) & (issued < len_q);
  assign d0_ready  = can_issue & ~owner;
  assign d1_ready  = can_issue & owner;

  assign mac_ivalid  = owner ? (d1_valid & d1_ready) : (d0_valid & d0_ready);
  assign mac_control = mac_ivalid & (issued == '0);
  assign mac_a       = mac_ivalid ? (owner ? d1_a : d0_a) : 32'h0;
  assign mac_b       = mac_ivalid ? (owner ? d1_b : d0_b) : 32'h0;

  assign res_valid = (state == HOLD);

  assign issued_nxt   = issued + 1'b1;
  assign returned_nxt = returned + 1'b1;
  assign ret_fire     = mac_ovalid & ((state == STREAM) | (state == DRAIN));
  assign last_ret     = ret_fire & (returned_nxt == len_q);

  // A zero-latency MAC can complete on the same cycle as the last issue, so
  // completion takes priority over the STREAM->DRAIN step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      len_q      <= '0;
      issued     <= '0;
      returned   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      res_data   <= 32'h0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len_q      <= accept_len;
            owner      <= accept_id;
            last_grant <= accept_id;
            issued     <= '0;
            returned   <= '0;
            if (accept_len == '0) begin
              res_data <= 32'h0;
              res_id   <= accept_id;
              state    <= HOLD;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (mac_ivalid) issued <= issued_nxt;
          if (ret_fire) returned <= returned_nxt;
          if (last_ret) begin
            res_data <= mac_result;
            res_id   <= owner;
            state    <= HOLD;
          end else if (mac_ivalid && (issued_nxt == len_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ret_fire) returned <= returned_nxt;
          if (last_ret) begin
            res_data <= mac_result;
            res_id   <= owner;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Directed bench for mac_dot_scheduler with a 7-cycle floating-point MAC model
// built on double-precision reals.
module tb_mac_dot_scheduler;

  localparam int LEN_W = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd0_valid = 1'b0, cmd1_valid = 1'b0;
  logic             cmd0_ready, cmd1_ready;
  logic [LEN_W-1:0] cmd0_len = '0, cmd1_len = '0;
  logic             d0_valid = 1'b0, d1_valid = 1'b0;
  logic             d0_ready, d1_ready;
  logic [31:0]      d0_a = '0, d0_b = '0, d1_a = '0, d1_b = '0;
  logic             mac_ivalid, mac_control;
  logic [31:0]      mac_a, mac_b;
  logic             mac_ovalid;
  logic [31:0]      mac_result;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic             res_id;

  int errors = 0;
  int checks = 0;
  int ivalid_cnt = 0;
  int ivalid_base;

  always #5 clock = ~clock;

  mac_dot_scheduler #(.LEN_W(LEN_W)) dut (
    .clock(clock), .resetn(resetn),
    .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_len(cmd0_len),
    .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_len(cmd1_len),
    .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_a(d0_a), .d0_b(d0_b),
    .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_a(d1_a), .d1_b(d1_b),
    .mac_ivalid(mac_ivalid), .mac_control(mac_control), .mac_a(mac_a), .mac_b(mac_b),
    .mac_ovalid(mac_ovalid), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'h0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // MAC model: keeps running after a DUT reset so stale results still emerge.
  logic [6:0]  pipe_v = '0;
  logic [31:0] pipe_r [7];
  real         acc_q = 0.0;
  real         prod, nacc;

  always_comb begin
    prod = sp2r(mac_a) * sp2r(mac_b);
    nacc = mac_control ? prod : acc_q + prod;
  end

  always @(posedge clock) begin
    pipe_v    <= {pipe_v[5:0], mac_ivalid};
    pipe_r[0] <= r2sp(nacc);
    for (int i = 1; i < 7; i++) pipe_r[i] <= pipe_r[i-1];
    if (mac_ivalid) acc_q <= nacc;
    if (mac_ivalid) ivalid_cnt <= ivalid_cnt + 1;
  end

  assign mac_ovalid = pipe_v[6];
  assign mac_result = pipe_r[6];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic issue_cmd(input int req, input logic [LEN_W-1:0] len);
    if (req == 0) begin cmd0_valid = 1'b1; cmd0_len = len; end
    else begin cmd1_valid = 1'b1; cmd1_len = len; end
    #1;
    check_output("cmd_ready", (req == 0) ? cmd0_ready : cmd1_ready, 32'd1);
    @(negedge clock);
    cmd0_valid = 1'b0;
    cmd1_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int req, input logic [31:0] a, input logic [31:0] b, input bit first);
    int n = 0;
    logic rdy;
    if (req == 0) begin d0_valid = 1'b1; d0_a = a; d0_b = b; end
    else begin d1_valid = 1'b1; d1_a = a; d1_b = b; end
    #1;
    rdy = (req == 0) ? d0_ready : d1_ready;
    while (!rdy && n < 50) begin
      @(negedge clock);
      #1;
      rdy = (req == 0) ? d0_ready : d1_ready;
      n++;
    end
    check_output("d_ready", rdy, 32'd1);
    check_output("mac_ivalid", mac_ivalid, 32'd1);
    check_output("mac_control", mac_control, first ? 32'd1 : 32'd0);
    check_output("mac_a", mac_a, a);
    @(negedge clock);
    d0_valid = 1'b0;
    d1_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [31:0] exp_data, input logic exp_id);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_output("res_valid", res_valid, 32'd1);
    check_output("res_data", res_data, exp_data);
    check_output("res_id", res_id, exp_id);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
  endtask

  initial begin
    // Reset state, with a pending command and operand that must not be acknowledged.
    cmd0_valid = 1'b1;
    d0_valid   = 1'b1;
    repeat (2) @(negedge clock);
    check_output("rst_cmd0_ready", cmd0_ready, 32'd0);
    check_output("rst_d0_ready", d0_ready, 32'd0);
    check_output("rst_mac_ivalid", mac_ivalid, 32'd0);
    check_output("rst_res_valid", res_valid, 32'd0);
    check_output("rst_res_data", res_data, 32'h0);
    cmd0_valid = 1'b0;
    d0_valid   = 1'b0;
    resetn     = 1'b1;
    @(negedge clock);

    // Contention: two len=1 jobs per requester, grant order 0,1,0,1.
    $display("[TB] round-robin arbitration");
    cmd0_valid = 1'b1; cmd0_len = 8'd1;
    cmd1_valid = 1'b1; cmd1_len = 8'd1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ta, tb, texp;
      int e;
      e = k % 2;
      case (k)
        0: begin ta = 32'h40000000; tb = 32'h40400000; texp = 32'h40C00000; end
        1: begin ta = 32'h3F800000; tb = 32'h40800000; texp = 32'h40800000; end
        2: begin ta = 32'h40400000; tb = 32'h40400000; texp = 32'h41100000; end
        default: begin ta = 32'h3F800000; tb = 32'h3F800000; texp = 32'h3F800000; end
      endcase
      #1;
      check_output("rr_cmd0_ready", cmd0_ready, (e == 0) ? 32'd1 : 32'd0);
      check_output("rr_cmd1_ready", cmd1_ready, (e == 1) ? 32'd1 : 32'd0);
      @(negedge clock);
      if (k == 2) cmd0_valid = 1'b0;
      if (k == 3) cmd1_valid = 1'b0;
      #1;
      check_output("busy_cmd_ready", cmd0_ready | cmd1_ready, 32'd0);
      apply_stimulus(e, ta, tb, 1'b1);
      wait_result(texp, e[0]);
    end

    // Requester 0, three pairs: 1*2 + 3*4 + 5*6 = 44.0.
    $display("[TB] len=3 dot product");
    ivalid_base = ivalid_cnt;
    issue_cmd(0, 8'd3);
    apply_stimulus(0, 32'h3F800000, 32'h40000000, 1'b1);
    apply_stimulus(0, 32'h40400000, 32'h40800000, 1'b0);
    apply_stimulus(0, 32'h40A00000, 32'h40C00000, 1'b0);
    wait_result(32'h42300000, 1'b0);
    check_output("len3_pulses", ivalid_cnt - ivalid_base, 32'd3);

    // Empty job from requester 1 completes the cycle after acceptance.
    $display("[TB] len=0 job");
    ivalid_base = ivalid_cnt;
    issue_cmd(1, 8'd0);
    check_output("len0_res_valid", res_valid, 32'd1);
    check_output("len0_res_data", res_data, 32'h0);
    check_output("len0_res_id", res_id, 32'd1);
    check_output("len0_d1_ready", d1_ready, 32'd0);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check_output("len0_released", res_valid, 32'd0);
    check_output("len0_no_pulses", ivalid_cnt - ivalid_base, 32'd0);

    // Bubbles between pairs and a stalled result: 1*1 + 2*2 + 1*2 + 2*3 = 13.0.
    $display("[TB] bubbles and result backpressure");
    ivalid_base = ivalid_cnt;
    issue_cmd(0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pa, pb;
      case (i)
        0: begin pa = 32'h3F800000; pb = 32'h3F800000; end
        1: begin pa = 32'h40000000; pb = 32'h40000000; end
        2: begin pa = 32'h3F800000; pb = 32'h40000000; end
        default: begin pa = 32'h40000000; pb = 32'h40400000; end
      endcase
      apply_stimulus(0, pa, pb, i == 0);
      #1;
      check_output("bubble_ivalid", mac_ivalid, 32'd0);
      @(negedge clock);
    end
    begin
      int n = 0;
      while (!res_valid && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check_output("stall_res_valid", res_valid, 32'd1);
      check_output("stall_res_data", res_data, 32'h41500000);
      @(negedge clock);
    end
    wait_result(32'h41500000, 1'b0);
    check_output("res_valid_drop", res_valid, 32'd0);
    check_output("bubble_pulses", ivalid_cnt - ivalid_base, 32'd4);

    // Reset mid-job after 2 of 5 pairs; stale MAC returns must be ignored.
    $display("[TB] reset mid-job");
    issue_cmd(0, 8'd5);
    apply_stimulus(0, 32'h40000000, 32'h40000000, 1'b1);
    apply_stimulus(0, 32'h40400000, 32'h40400000, 1'b0);
    d0_valid   = 1'b1;
    cmd0_valid = 1'b1;
    resetn     = 1'b0;
    #1;
    check_output("abort_d0_ready", d0_ready, 32'd0);
    check_output("abort_mac_ivalid", mac_ivalid, 32'd0);
    check_output("abort_mac_control", mac_control, 32'd0);
    check_output("abort_cmd0_ready", cmd0_ready, 32'd0);
    check_output("abort_res_valid", res_valid, 32'd0);
    check_output("abort_res_data", res_data, 32'h0);
    check_output("abort_res_id", res_id, 32'd0);
    @(negedge clock);
    d0_valid   = 1'b0;
    cmd0_valid = 1'b0;
    resetn     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check_output("stale_res_valid", res_valid, 32'd0);
    end
    issue_cmd(0, 8'd1);
    apply_stimulus(0, 32'h40400000, 32'h40A00000, 1'b1);
    wait_result(32'h41700000, 1'b0);

    // Longest job: 255 pairs of 1.0*1.0 must not wrap the counters.
    $display("[TB] maximum length job");
    ivalid_base = ivalid_cnt;
    issue_cmd(1, 8'd255);
    for (int i = 0; i < 255; i++) apply_stimulus(1, 32'h3F800000, 32'h3F800000, i == 0);
    #1;
    check_output("max_d1_ready", d1_ready, 32'd0);
    wait_result(32'h437F0000, 1'b1);
    check_output("max_pulses", ivalid_cnt - ivalid_base, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
